fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode sequencer: boots the PC, fetches from instruction
// memory, resolves jumps/halt locally and hands plain instructions to execute.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | load PC with RESET_VEC (one cycle after reset)
// FETCH  | request instruction at PC_CURR, wait for mem_ack
// DECODE | resolve HLT/JMP/JZ; plain opcodes go on to ISSUE
// ISSUE  | present INSTR to execute until instr_ready
// HALT   | stopped until rst
module fetch_ctrl #(
    parameter logic [3:0] RESET_VEC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] PC_CURR,
    output logic [3:0] MEM_ADDR,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] MEM_DATA,
    input  logic       zero,
    output logic [3:0] PC_INIT,
    output logic       set_pc,
    output logic       pc_step,
    output logic [7:0] INSTR,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] instr_q;
    logic [3:0] opcode;
    logic [3:0] operand;

    assign INSTR   = instr_q;
    assign opcode  = instr_q[7:4];
    assign operand = instr_q[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_LOAD;
            instr_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ack) begin
                instr_q <= MEM_DATA;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        MEM_ADDR    = PC_CURR;
        mem_req     = 1'b0;
        PC_INIT     = 4'h0;
        set_pc      = 1'b0;
        pc_step     = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            S_LOAD: begin
                // PC load is suppressed while reset is still held
                PC_INIT   = RESET_VEC;
                set_pc    = ~rst;
                pc_step   = ~rst;
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT: begin
                        state_nxt = S_HALT;
                    end
                    OP_JMP: begin
                        set_pc    = 1'b1;
                        PC_INIT   = operand;
                        pc_step   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_JZ: begin
                        set_pc    = zero;
                        PC_INIT   = zero ? operand : 4'h0;
                        pc_step   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    default: begin
                        state_nxt = S_ISSUE;
                    end
                endcase
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_step   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: external PC model, hand-driven memory and
// execute handshakes, scoreboard of instructions expected at the issue port.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] PC_CURR;
    logic [3:0] MEM_ADDR;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] MEM_DATA;
    logic       zero;
    logic [3:0] PC_INIT;
    logic       set_pc;
    logic       pc_step;
    logic [7:0] INSTR;
    logic       instr_valid;
    logic       instr_ready;
    logic       halted;

    logic [3:0] pc = 4'h0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_instr;
    int         n_pass = 0;
    int         n_total = 0;

    fetch_ctrl #(.RESET_VEC(4'h3)) dut (
        .clk        (clk),
        .rst        (rst),
        .PC_CURR    (PC_CURR),
        .MEM_ADDR   (MEM_ADDR),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .MEM_DATA   (MEM_DATA),
        .zero       (zero),
        .PC_INIT    (PC_INIT),
        .set_pc     (set_pc),
        .pc_step    (pc_step),
        .INSTR      (INSTR),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // program counter owned by the surrounding datapath
    always @(posedge clk) begin
        if (pc_step === 1'b1) begin
            pc <= (set_pc === 1'b1) ? PC_INIT : pc + 4'd1;
        end
    end
    assign PC_CURR = pc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [3:0] addr, input logic [7:0] data, input int waits);
        for (int i = 0; i < waits; i++) begin
            mem_ack  = 1'b0;
            MEM_DATA = 8'h5A;
            #1;
            chk("fetch_wait_req", 8'(mem_req), 8'h1);
            chk("fetch_wait_addr", 8'(MEM_ADDR), 8'(addr));
            tick();
        end
        mem_ack  = 1'b1;
        MEM_DATA = data;
        #1;
        chk("fetch_req", 8'(mem_req), 8'h1);
        chk("fetch_addr", 8'(MEM_ADDR), 8'(addr));
        chk("fetch_no_valid", 8'(instr_valid), 8'h0);
        if (data[7:4] < 4'hD) begin
            exp_q.push_back(data);
        end
        tick();
        mem_ack  = 1'b0;
        MEM_DATA = 8'h5A;
        #1;
        chk("latched_instr", INSTR, data);
    endtask

    task automatic decode_plain();
        chk("dec_no_valid", 8'(instr_valid), 8'h0);
        chk("dec_no_step", 8'(pc_step), 8'h0);
        chk("dec_no_set", 8'(set_pc), 8'h0);
        chk("dec_no_req", 8'(mem_req), 8'h0);
        tick();
    endtask

    task automatic decode_branch(input logic zv, input logic exp_set, input logic [3:0] exp_init);
        zero = zv;
        #1;
        chk("br_set_pc", 8'(set_pc), 8'(exp_set));
        chk("br_pc_step", 8'(pc_step), 8'h1);
        chk("br_pc_init", 8'(PC_INIT), 8'(exp_init));
        chk("br_no_valid", 8'(instr_valid), 8'h0);
        tick();
        zero = 1'b0;
    endtask

    task automatic issue(input int stall);
        chk("sb_not_empty", 8'(exp_q.size() != 0), 8'h1);
        exp_instr = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            mem_ack     = 1'b1;
            MEM_DATA    = 8'hAA;
            #1;
            chk("stall_valid", 8'(instr_valid), 8'h1);
            chk("stall_no_step", 8'(pc_step), 8'h0);
            chk("stall_instr", INSTR, exp_instr);
            tick();
        end
        mem_ack     = 1'b0;
        MEM_DATA    = 8'h5A;
        instr_ready = 1'b1;
        #1;
        chk("acc_valid", 8'(instr_valid), 8'h1);
        chk("acc_step", 8'(pc_step), 8'h1);
        chk("acc_no_set", 8'(set_pc), 8'h0);
        chk("acc_instr", INSTR, exp_instr);
        tick();
        instr_ready = 1'b0;
    endtask

    task automatic load_cycle();
        #1;
        chk("load_set_pc", 8'(set_pc), 8'h1);
        chk("load_pc_step", 8'(pc_step), 8'h1);
        chk("load_pc_init", 8'(PC_INIT), 8'h3);
        chk("load_no_req", 8'(mem_req), 8'h0);
        tick();
        chk("boot_req", 8'(mem_req), 8'h1);
        chk("boot_addr", 8'(MEM_ADDR), 8'h3);
        chk("boot_init_zero", 8'(PC_INIT), 8'h0);
    endtask

    task automatic in_reset_checks();
        chk("rst_req", 8'(mem_req), 8'h0);
        chk("rst_valid", 8'(instr_valid), 8'h0);
        chk("rst_set_pc", 8'(set_pc), 8'h0);
        chk("rst_pc_step", 8'(pc_step), 8'h0);
        chk("rst_halted", 8'(halted), 8'h0);
        chk("rst_instr", INSTR, 8'h00);
        chk("rst_pc_init", 8'(PC_INIT), 8'h3);
    endtask

    initial begin
        rst         = 1'b1;
        mem_ack     = 1'b0;
        MEM_DATA    = 8'h00;
        zero        = 1'b0;
        instr_ready = 1'b0;
        repeat (3) tick();
        in_reset_checks();

        // boot
        rst = 1'b0;
        load_cycle();

        // straight line with memory and execute stalls
        do_fetch(4'h3, 8'h25, 2);
        decode_plain();
        issue(3);

        // branches
        do_fetch(4'h4, 8'hE9, 0);
        decode_branch(1'b0, 1'b1, 4'h9);
        do_fetch(4'h9, 8'hD4, 0);
        decode_branch(1'b0, 1'b0, 4'h0);
        do_fetch(4'hA, 8'hD4, 1);
        decode_branch(1'b1, 1'b1, 4'h4);

        // wrap from F to 0
        do_fetch(4'h4, 8'hEF, 0);
        decode_branch(1'b0, 1'b1, 4'hF);
        do_fetch(4'hF, 8'h31, 0);
        decode_plain();
        issue(0);
        do_fetch(4'h0, 8'h47, 0);
        decode_plain();
        issue(1);

        // self-jump loops
        do_fetch(4'h1, 8'hE1, 0);
        decode_branch(1'b0, 1'b1, 4'h1);
        do_fetch(4'h1, 8'hE1, 0);
        decode_branch(1'b1, 1'b1, 4'h1);

        // halt, with stray acks ignored
        do_fetch(4'h1, 8'hF0, 0);
        chk("hlt_dec_step", 8'(pc_step), 8'h0);
        chk("hlt_dec_set", 8'(set_pc), 8'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            mem_ack     = 1'b1;
            instr_ready = 1'b1;
            #1;
            chk("halt_flag", 8'(halted), 8'h1);
            chk("halt_no_req", 8'(mem_req), 8'h0);
            chk("halt_no_step", 8'(pc_step), 8'h0);
            chk("halt_no_valid", 8'(instr_valid), 8'h0);
            chk("halt_instr", INSTR, 8'hF0);
            tick();
        end
        mem_ack     = 1'b0;
        instr_ready = 1'b0;

        // reset out of HALT
        rst = 1'b1;
        tick();
        in_reset_checks();
        rst = 1'b0;
        load_cycle();

        // reset in the middle of a stalled fetch
        tick();
        chk("mid_fetch_req", 8'(mem_req), 8'h1);
        rst = 1'b1;
        tick();
        in_reset_checks();
        rst = 1'b0;
        load_cycle();

        chk("sb_drained", 8'(exp_q.size()), 8'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
